// File: rtl/alu_issue_seq.sv
// Issue sequencer for the 4-bit-control ALU: decodes MIPS opcode/funct, registers
// the ALU operands, captures the ALU result one cycle later and returns it on a handshake.
module alu_issue_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_ou,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_taken,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } br_t;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  // Packed decode result: {legal, branch kind[1:0], ctrl[3:0]}
  function automatic logic [6:0] decode_op(input logic [5:0] opcode, input logic [5:0] funct);
    logic [6:0] d;
    d = {1'b0, BR_NONE, CTRL_AND};
    if (opcode == 6'b000000) begin
      case (funct)
        6'b100000: d = {1'b1, BR_NONE, CTRL_ADD};
        6'b100010: d = {1'b1, BR_NONE, CTRL_SUB};
        6'b100100: d = {1'b1, BR_NONE, CTRL_AND};
        6'b100101: d = {1'b1, BR_NONE, CTRL_OR};
        6'b101010: d = {1'b1, BR_NONE, CTRL_SLT};
        6'b100111: d = {1'b1, BR_NONE, CTRL_NOR};
        default:   d = {1'b0, BR_NONE, CTRL_AND};
      endcase
    end else begin
      case (opcode)
        6'b100011: d = {1'b1, BR_NONE, CTRL_ADD};
        6'b101011: d = {1'b1, BR_NONE, CTRL_ADD};
        6'b001000: d = {1'b1, BR_NONE, CTRL_ADD};
        6'b000100: d = {1'b1, BR_EQ,   CTRL_SUB};
        6'b000101: d = {1'b1, BR_NE,   CTRL_SUB};
        6'b001100: d = {1'b1, BR_NONE, CTRL_AND};
        6'b001101: d = {1'b1, BR_NONE, CTRL_OR};
        6'b001010: d = {1'b1, BR_NONE, CTRL_SLT};
        default:   d = {1'b0, BR_NONE, CTRL_AND};
      endcase
    end
    return d;
  endfunction

  state_t      state_r;
  br_t         br_r;
  logic [31:0] alu_in1_r;
  logic [31:0] alu_in2_r;
  logic [3:0]  alu_ctrl_r;
  logic [31:0] rsp_result_r;
  logic        rsp_taken_r;
  logic        rsp_err_r;

  logic        dec_legal_s;
  br_t         dec_br_s;
  logic [3:0]  dec_ctrl_s;
  logic        accept_s;

  // Decode the presented request and qualify acceptance with the IDLE state
  always_comb begin
    logic [6:0] d;
    d           = decode_op(req_opcode, req_funct);
    dec_legal_s = d[6];
    dec_br_s    = br_t'(d[5:4]);
    dec_ctrl_s  = d[3:0];
    if (state_r == IDLE) begin
      accept_s = req_valid;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Sequencer FSM with registered ALU drive and response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      br_r         <= BR_NONE;
      alu_in1_r    <= 32'h0000_0000;
      alu_in2_r    <= 32'h0000_0000;
      alu_ctrl_r   <= 4'b0000;
      rsp_result_r <= 32'h0000_0000;
      rsp_taken_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (dec_legal_s) begin
              alu_in1_r  <= req_a;
              alu_in2_r  <= req_b;
              alu_ctrl_r <= dec_ctrl_s;
              br_r       <= dec_br_s;
              state_r    <= ISSUE;
            end else begin
              // Illegal ops skip the ALU entirely; its operands keep their last values
              rsp_result_r <= 32'h0000_0000;
              rsp_taken_r  <= 1'b0;
              rsp_err_r    <= 1'b1;
              state_r      <= RESP;
            end
          end
        end
        ISSUE: begin
          rsp_result_r <= alu_ou;
          rsp_err_r    <= 1'b0;
          case (br_r)
            BR_EQ:   rsp_taken_r <= alu_zero;
            BR_NE:   rsp_taken_r <= ~alu_zero;
            default: rsp_taken_r <= 1'b0;
          endcase
          state_r <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign rsp_valid  = (state_r == RESP);
  assign alu_in1    = alu_in1_r;
  assign alu_in2    = alu_in2_r;
  assign alu_ctrl   = alu_ctrl_r;
  assign rsp_result = rsp_result_r;
  assign rsp_taken  = rsp_taken_r;
  assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU on the ALU side, expected responses
// queued at request time and compared when the sequencer answers.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_ou;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_taken;
  logic        rsp_err;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_ou(alu_ou), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_taken(rsp_taken), .rsp_err(rsp_err)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      4'b1100: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  // Combinational ALU seen by the sequencer
  always_comb begin
    alu_ou   = ref_alu(alu_ctrl, alu_in1, alu_in2);
    alu_zero = (alu_ou == 32'h0);
  end

  typedef struct packed {
    logic [31:0] result;
    logic        taken;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic [1:0] br;
  } op_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] last_ctrl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'h1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h0, 32'h1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_result"}, rsp_result, e.result);
      chk({tag, "_taken"}, 32'(rsp_taken), 32'(e.taken));
      chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  task automatic release_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rsp_valid_fall"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_req_ready_rise"}, 32'(req_ready), 32'h1);
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic legal,
                       input logic [3:0] ctrl, input logic [31:0] res, input logic tk);
    exp_t e;
    wait_ready();
    e.result = legal ? res : 32'h0;
    e.taken  = legal ? tk : 1'b0;
    e.err    = ~legal;
    sbq.push_back(e);
    req_opcode = op; req_funct = fn; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_req_ready_low"}, 32'(req_ready), 32'h0);
    if (legal) begin
      chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(ctrl));
      chk({tag, "_in1"}, alu_in1, a);
      chk({tag, "_in2"}, alu_in2, b);
      chk({tag, "_rsp_valid_e0"}, 32'(rsp_valid), 32'h0);
      last_ctrl = ctrl;
      @(posedge clk); #1;
    end else begin
      chk({tag, "_ctrl_kept"}, 32'(alu_ctrl), 32'(last_ctrl));
    end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
    pop_check(tag);
    release_rsp(tag);
  endtask

  op_t optab[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    optab[0]  = {6'b000000, 6'b100000, 4'b0010, 2'd0};
    optab[1]  = {6'b000000, 6'b100010, 4'b0110, 2'd0};
    optab[2]  = {6'b000000, 6'b100100, 4'b0000, 2'd0};
    optab[3]  = {6'b000000, 6'b100101, 4'b0001, 2'd0};
    optab[4]  = {6'b000000, 6'b101010, 4'b0111, 2'd0};
    optab[5]  = {6'b000000, 6'b100111, 4'b1100, 2'd0};
    optab[6]  = {6'b100011, 6'b000000, 4'b0010, 2'd0};
    optab[7]  = {6'b101011, 6'b000000, 4'b0010, 2'd0};
    optab[8]  = {6'b001000, 6'b000000, 4'b0010, 2'd0};
    optab[9]  = {6'b000100, 6'b000000, 4'b0110, 2'd1};
    optab[10] = {6'b000101, 6'b000000, 4'b0110, 2'd2};
    optab[11] = {6'b001100, 6'b000000, 4'b0000, 2'd0};
    optab[12] = {6'b001101, 6'b000000, 4'b0001, 2'd0};
    optab[13] = {6'b001010, 6'b000000, 4'b0111, 2'd0};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = 6'h0; req_funct = 6'h0; req_a = 32'h0; req_b = 32'h0;
    last_ctrl = 4'b0000;
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_alu_in1", alu_in1, 32'h0);
    chk("reset_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add", 6'b000000, 6'b100000, 32'd5, 32'd7, 1'b1, 4'b0010, 32'd12, 1'b0);
    do_op("beq", 6'b000100, 6'b000000, 32'd9, 32'd9, 1'b1, 4'b0110, 32'd0, 1'b1);
    do_op("bne", 6'b000101, 6'b000000, 32'd9, 32'd9, 1'b1, 4'b0110, 32'd0, 1'b0);
    do_op("bne_diff", 6'b000101, 6'b000000, 32'd9, 32'd4, 1'b1, 4'b0110, 32'd5, 1'b1);
    do_op("slti", 6'b001010, 6'b000000, 32'd3, 32'd4, 1'b1, 4'b0111, 32'd1, 1'b0);
    do_op("nor", 6'b000000, 6'b100111, 32'd0, 32'd0, 1'b1, 4'b1100, 32'hFFFF_FFFF, 1'b0);
    do_op("illegal_funct", 6'b000000, 6'b000011, 32'd1, 32'd2, 1'b0, 4'b0000, 32'h0, 1'b0);
    do_op("illegal_op", 6'b111111, 6'b100000, 32'd1, 32'd2, 1'b0, 4'b0000, 32'h0, 1'b0);

    // Randomised legal ops from the decode table, with occasional illegal ones
    for (int i = 0; i < 16; i++) begin
      int k;
      logic [31:0] a, b, r;
      logic tk;
      k = $urandom_range(0, 13);
      a = $urandom;
      b = (i % 4 == 0) ? a : 32'($urandom);
      r = ref_alu(optab[k].ctrl, a, b);
      tk = (optab[k].br == 2'd1) ? (r == 32'h0) : (optab[k].br == 2'd2) ? (r != 32'h0) : 1'b0;
      if (i % 5 == 3)
        do_op("rand_illegal", 6'b000001, 6'b000000, a, b, 1'b0, 4'b0000, 32'h0, 1'b0);
      else
        do_op("rand", optab[k].op, optab[k].fn, a, b, 1'b1, optab[k].ctrl, r, tk);
    end

    // Backpressure with a second request waiting
    wait_ready();
    sbq.push_back('{result: 32'd12, taken: 1'b0, err: 1'b0});
    req_opcode = 6'b000000; req_funct = 6'b100000; req_a = 32'd5; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    req_opcode = 6'b001101; req_funct = 6'b000000; req_a = 32'hF0; req_b = 32'h0F; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_result_stable", rsp_result, 32'd12);
      chk("bp_ctrl_stable", 32'(alu_ctrl), 32'h2);
    end
    pop_check("bp_first");
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_rsp_valid_fall", 32'(rsp_valid), 32'h0);
    chk("bp_req_ready_rise", 32'(req_ready), 32'h1);
    chk("bp_not_yet_accepted", 32'(alu_ctrl), 32'h2);
    sbq.push_back('{result: 32'hFF, taken: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_second_accepted", 32'(req_ready), 32'h0);
    chk("bp_second_ctrl", 32'(alu_ctrl), 32'h1);
    @(posedge clk); #1;
    chk("bp_second_rsp_valid", 32'(rsp_valid), 32'h1);
    pop_check("bp_second");
    release_rsp("bp_second");
    last_ctrl = 4'b0001;

    // Asynchronous reset while in ISSUE; the in-flight op is dropped
    wait_ready();
    req_opcode = 6'b001000; req_funct = 6'b000000; req_a = 32'h1234; req_b = 32'h1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_issue_ctrl", 32'(alu_ctrl), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("async_rst_req_ready", 32'(req_ready), 32'h1);
    chk("async_rst_ctrl", 32'(alu_ctrl), 32'h0);
    chk("async_rst_in1", alu_in1, 32'h0);
    chk("async_rst_in2", alu_in2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(rsp_valid), 32'h0);
    chk("post_rst_result", rsp_result, 32'h0);
    last_ctrl = 4'b0000;
    do_op("post_rst_illegal", 6'b000010, 6'b000000, 32'd1, 32'd1, 1'b0, 4'b0000, 32'h0, 1'b0);
    do_op("post_rst_sub", 6'b000000, 6'b100010, 32'd3, 32'd5, 1'b1, 4'b0110, 32'hFFFF_FFFE, 1'b0);

    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Multi-cycle issue sequencer that drives the 4-bit-control combinational ALU (ports `in1`, `in2`, `ctrl`, `ou`, `zero`) from the instruction side. It accepts one operation per request handshake, decodes MIPS opcode/funct into the ALU control code, and registers the ALU operands and control. It then captures `ou`/`zero` one cycle later and returns result, branch outcome and an illegal-op flag on a response handshake. It sits between decode and the ALU in the multi-cycle datapath.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept; high only in IDLE.
- `req_opcode`  in  6  instruction bits [31:26].
- `req_funct`  in  6  instruction bits [5:0]; used only when opcode = 000000.
- `req_a`  in  32  operand A (rs value).
- `req_b`  in  32  operand B (rt value or immediate, already extended by caller).
- `alu_in1`  out  32  registered ALU operand 1.
- `alu_in2`  out  32  registered ALU operand 2.
- `alu_ctrl`  out  4  registered ALU control.
- `alu_ou`  in  32  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  32  captured ALU result; 0 on illegal op.
- `rsp_taken`  out  1  branch outcome; 0 for non-branch ops.
- `rsp_err`  out  1  illegal opcode/funct.

## Operation
- Control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- R-type decode (opcode 000000), by funct:
  - 100000 → ADD; 100010 → SUB; 100100 → AND.
  - 100101 → OR; 101010 → SLT; 100111 → NOR.
  - Any other funct is illegal.
- I-type decode, by opcode:
  - 100011 lw, 101011 sw, 001000 addi → ADD.
  - 000100 beq, 000101 bne → SUB.
  - 001100 andi → AND; 001101 ori → OR; 001010 slti → SLT.
  - Any other opcode is illegal.
- Branch outcome: beq → `rsp_taken` = captured `alu_zero`; bne → `rsp_taken` = !`alu_zero`; all other ops → 0.
- FSM states IDLE, ISSUE, RESP:
  - IDLE → ISSUE on `req_valid`&&`req_ready` with a legal op. Load `alu_in1`=`req_a`, `alu_in2`=`req_b`, `alu_ctrl`=decoded code; latch the branch kind.
  - IDLE → RESP on acceptance of an illegal op. Load `rsp_err`=1, `rsp_result`=0, `rsp_taken`=0. ALU outputs are not updated.
  - ISSUE → RESP unconditionally. Capture `alu_ou` into `rsp_result`, compute `rsp_taken`, set `rsp_err`=0.
  - RESP → IDLE on `rsp_ready`.
- `alu_in1`/`alu_in2`/`alu_ctrl` hold their last issued values outside ISSUE; they never return to 0 except on reset.
- `rsp_*` fields are stable for as long as `rsp_valid`=1.

## Timing
- Reset (asynchronous, any state, including mid-ISSUE or RESP):
  - State → IDLE.
  - `req_ready`=1 (combinational from IDLE); `rsp_valid`=0.
  - `rsp_result`=0, `rsp_taken`=0, `rsp_err`=0.
  - `alu_in1`=0, `alu_in2`=0, `alu_ctrl`=0000.
  - Any in-flight operation is dropped.
- Legal-op latency: accept at edge E0; ALU settles during the ISSUE cycle; result captured at E1; `rsp_valid` is high from E1.
- Illegal-op latency: `rsp_valid` is high from E0.
- `rsp_valid` stays high while `rsp_ready`=0. It falls at the first edge where `rsp_ready`=1; `req_ready` rises in that same cycle.
- No overlap: a request presented during ISSUE or RESP waits (`req_ready`=0). Throughput is at most one op per 3 cycles with `rsp_ready` held high, or 2 cycles for illegal ops.
- `req_ready` depends only on state, never on `req_valid`. `rsp_ready` is only sampled in RESP.

## Test plan
- Reset: assert `rst_n`=0 mid-ISSUE → `rsp_valid`=0, `req_ready`=1, `alu_ctrl`=0000, `alu_in1`=0 immediately, without a clock edge.
- R-type add: opcode 000000, funct 100000, a=5, b=7 → `alu_ctrl`=0010 after E0; `rsp_valid` from E1 with `rsp_result`=12, `rsp_taken`=0, `rsp_err`=0.
- beq/bne: opcode 000100 with a=9, b=9 → `alu_ctrl`=0110, `rsp_result`=0, `rsp_taken`=1. Opcode 000101 with the same operands → `rsp_taken`=0.
- slti / nor: opcode 001010 with a=3, b=4 → `rsp_result`=1. R-type funct 100111 with a=0, b=0 → `rsp_result`=FFFFFFFF.
- Illegal op: opcode 000000, funct 000011 → `rsp_valid` from E0 with `rsp_err`=1 and `rsp_result`=0; `alu_ctrl` keeps its prior value.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with a second `req_valid` pending → response fields stable and `req_ready`=0 throughout. Second request accepted only in the cycle after `rsp_ready`=1.
